// File: rtl/mac_pkg.sv
// Shared constants for the MAC encoder: header word layout, frame limits,
// CRC-32 parameters and FSM state encodings.
package mac_pkg;

  localparam int HEADER_DWIDTH = 128;
  localparam int N_PORTS       = 4;

  // Header word: {RSVD[11:0], FCS_OK, IS_CTRL, PORT[1:0], SRC[47:0], DST[47:0], TYPE[15:0]}
  localparam int TYPE_LSB    = 0;
  localparam int DST_LSB     = 16;
  localparam int SRC_LSB     = 64;
  localparam int PORT_LSB    = 112;
  localparam int IS_CTRL_BIT = 114;
  localparam int FCS_OK_BIT  = 115;
  localparam int RSVD_LSB    = 116;

  localparam int          MIN_FRAME     = 60;
  localparam logic [31:0] FCS_RESIDUE   = 32'hC704_DD7B;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PAD     = 3'd3,
    S_FCS     = 3'd4,
    S_DROP    = 3'd5,
    S_END     = 3'd6
  } state_t;

endpackage

// File: rtl/mac_enc_if.sv
// FIFO-side signal bundle of the MAC encoder: header/body FWFT FIFOs in,
// four PHY TX FIFOs out. master = encoder side, slave = FIFO side.
interface mac_enc_if;
  import mac_pkg::*;

  logic [HEADER_DWIDTH-1:0] h_fifo_dout;
  logic                     h_fifo_empty;
  logic                     h_fifo_rden;

  logic [7:0] b_fifo_dout;
  logic       b_fifo_empty;
  logic       b_fifo_del;
  logic       b_fifo_rden;

  logic [7:0] o0_fifo_din, o1_fifo_din, o2_fifo_din, o3_fifo_din;
  logic       o0_fifo_wren, o1_fifo_wren, o2_fifo_wren, o3_fifo_wren;
  logic       o0_fifo_del, o1_fifo_del, o2_fifo_del, o3_fifo_del;
  logic       o0_fifo_afull, o1_fifo_afull, o2_fifo_afull, o3_fifo_afull;

  modport master (
    input  h_fifo_dout, h_fifo_empty, b_fifo_dout, b_fifo_empty, b_fifo_del,
    input  o0_fifo_afull, o1_fifo_afull, o2_fifo_afull, o3_fifo_afull,
    output h_fifo_rden, b_fifo_rden,
    output o0_fifo_din, o1_fifo_din, o2_fifo_din, o3_fifo_din,
    output o0_fifo_wren, o1_fifo_wren, o2_fifo_wren, o3_fifo_wren,
    output o0_fifo_del, o1_fifo_del, o2_fifo_del, o3_fifo_del
  );

  modport slave (
    output h_fifo_dout, h_fifo_empty, b_fifo_dout, b_fifo_empty, b_fifo_del,
    output o0_fifo_afull, o1_fifo_afull, o2_fifo_afull, o3_fifo_afull,
    input  h_fifo_rden, b_fifo_rden,
    input  o0_fifo_din, o1_fifo_din, o2_fifo_din, o3_fifo_din,
    input  o0_fifo_wren, o1_fifo_wren, o2_fifo_wren, o3_fifo_wren,
    input  o0_fifo_del, o1_fifo_del, o2_fifo_del, o3_fifo_del
  );

endinterface

// File: rtl/mac_enc_crc.sv
// Byte-wide reflected CRC-32 (Ethernet polynomial); state presets to all ones
// on rst and advances one byte per cycle while crc_en is high.
module mac_enc_crc
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        crc_en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_reg, crc_next;

  always_comb begin
    crc_next = crc_reg ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY_REFL) : (crc_next >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg <= CRC_INIT;
    end else if (crc_en) begin
      crc_reg <= crc_next;
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/mac_enc.sv
// Ethernet frame encoder: header + body FIFOs -> one of four PHY TX FIFOs, CRC-32 FCS appended.
// Build option MAC_ENC_PAD_EN: zero-pad short frames up to MIN_FRAME bytes before the FCS.
module mac_enc
  import mac_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  mac_enc_if.master bus
);

  state_t             state_reg, state_next;
  logic [10:0]        cnt_reg, cnt_next, cnt_inc;
  logic [1:0]         fcs_idx_reg, fcs_idx_next;
  logic [1:0]         port_reg, port_next;
  logic [111:0]       hdr_reg, hdr_next;
  logic [1:0]         hdr_port;
  logic [N_PORTS-1:0] afull_vec;
  logic               h_rden, b_rden, tx_wr, tx_del, crc_en, crc_clr;
  logic [7:0]         tx_byte;
  logic [31:0]        crc_val, crc_inv;
  logic [N_PORTS-1:0] sel, wren_next, del_next, wren_reg, del_reg;
  logic [7:0]         din_next [N_PORTS];
  logic [7:0]         din_reg  [N_PORTS];
  logic               unused_hdr_bits;

  assign hdr_port  = bus.h_fifo_dout[PORT_LSB +: 2];
  assign afull_vec = {bus.o3_fifo_afull, bus.o2_fifo_afull, bus.o1_fifo_afull, bus.o0_fifo_afull};
  assign cnt_inc   = (cnt_reg == 11'h7FF) ? cnt_reg : cnt_reg + 11'd1;
  assign crc_inv   = ~crc_val;
  assign unused_hdr_bits = ^{bus.h_fifo_dout[HEADER_DWIDTH-1:RSVD_LSB], bus.h_fifo_dout[IS_CTRL_BIT]};

  mac_enc_crc u_crc (
    .clk    (clk),
    .rst    (rst | crc_clr),
    .crc_en (crc_en),
    .data   (tx_byte),
    .crc    (crc_val)
  );

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    fcs_idx_next = fcs_idx_reg;
    port_next    = port_reg;
    hdr_next     = hdr_reg;
    h_rden       = 1'b0;
    b_rden       = 1'b0;
    tx_wr        = 1'b0;
    tx_del       = 1'b0;
    tx_byte      = 8'h00;
    crc_en       = 1'b0;
    crc_clr      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!bus.h_fifo_empty && !afull_vec[hdr_port]) begin
          h_rden     = 1'b1;
          port_next  = hdr_port;
          // Stored in emission order so S_HDR just shifts out the top byte.
          hdr_next   = {bus.h_fifo_dout[DST_LSB +: 48], bus.h_fifo_dout[SRC_LSB +: 48],
                        bus.h_fifo_dout[TYPE_LSB +: 16]};
          state_next = bus.h_fifo_dout[FCS_OK_BIT] ? S_HDR : S_DROP;
        end
      end
      S_HDR: begin
        tx_wr    = 1'b1;
        crc_en   = 1'b1;
        tx_byte  = hdr_reg[111:104];
        hdr_next = {hdr_reg[103:0], 8'h00};
        cnt_next = cnt_inc;
        if (cnt_reg == 11'd13) state_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (!bus.b_fifo_empty) begin
          b_rden   = 1'b1;
          tx_wr    = 1'b1;
          crc_en   = 1'b1;
          tx_byte  = bus.b_fifo_dout;
          cnt_next = cnt_inc;
          if (bus.b_fifo_del) begin
`ifdef MAC_ENC_PAD_EN
            state_next = (cnt_inc < 11'(MIN_FRAME)) ? S_PAD : S_FCS;
`else
            state_next = S_FCS;
`endif
          end
        end
      end
`ifdef MAC_ENC_PAD_EN
      S_PAD: begin
        tx_wr    = 1'b1;
        crc_en   = 1'b1;
        cnt_next = cnt_inc;
        if (cnt_inc >= 11'(MIN_FRAME)) state_next = S_FCS;
      end
`endif
      S_FCS: begin
        tx_wr        = 1'b1;
        tx_byte      = crc_inv[{fcs_idx_reg, 3'b000} +: 8];
        fcs_idx_next = fcs_idx_reg + 2'd1;
        if (fcs_idx_reg == 2'd3) begin
          tx_del     = 1'b1;
          state_next = S_END;
        end
      end
      S_DROP: begin
        if (!bus.b_fifo_empty) begin
          b_rden = 1'b1;
          if (bus.b_fifo_del) state_next = S_END;
        end
      end
      S_END: begin
        crc_clr      = 1'b1;
        cnt_next     = 11'd0;
        fcs_idx_next = 2'd0;
        state_next   = S_IDLE;
      end
      default: state_next = S_END;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 11'd0;
      fcs_idx_reg <= 2'd0;
      port_reg    <= 2'd0;
      hdr_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      fcs_idx_reg <= fcs_idx_next;
      port_reg    <= port_next;
      hdr_reg     <= hdr_next;
    end
  end

  // Only the latched port sees traffic; every other port is held at zero.
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign sel[gi]       = tx_wr && (port_reg == 2'(gi));
    assign wren_next[gi] = sel[gi];
    assign del_next[gi]  = sel[gi] && tx_del;
    assign din_next[gi]  = sel[gi] ? tx_byte : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wren_reg <= '0;
      del_reg  <= '0;
      din_reg  <= '{default: 8'h00};
    end else begin
      wren_reg <= wren_next;
      del_reg  <= del_next;
      din_reg  <= din_next;
    end
  end

  assign bus.h_fifo_rden  = h_rden & ~rst;
  assign bus.b_fifo_rden  = b_rden & ~rst;
  assign bus.o0_fifo_din  = din_reg[0];
  assign bus.o1_fifo_din  = din_reg[1];
  assign bus.o2_fifo_din  = din_reg[2];
  assign bus.o3_fifo_din  = din_reg[3];
  assign bus.o0_fifo_wren = wren_reg[0];
  assign bus.o1_fifo_wren = wren_reg[1];
  assign bus.o2_fifo_wren = wren_reg[2];
  assign bus.o3_fifo_wren = wren_reg[3];
  assign bus.o0_fifo_del  = del_reg[0];
  assign bus.o1_fifo_del  = del_reg[1];
  assign bus.o2_fifo_del  = del_reg[2];
  assign bus.o3_fifo_del  = del_reg[3];

endmodule

// File: tb/tb_mac_enc.sv
// Self-checking bench for mac_enc: FIFO models on queues, a frame-level reference
// model producing the expected TX byte stream per port, and a per-cycle compare process.
module tb_mac_enc;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_enc_if bus ();

  mac_enc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [127:0] hq [$];
  logic [8:0]   bq [$];
  logic [8:0]   exp_q [4][$];
  logic [7:0]   rx_q [4][$];
  int           rx_len [4];
  logic [7:0]   rx_first [4];
  int           frames_done = 0;
  int           wr_total = 0;
  int           h_pop_cnt = 0;
  int           b_pop_cnt = 0;
  logic         h_pop = 1'b0;
  logic         b_pop = 1'b0;
  int           stall_cnt = 0;
  bit           rand_stall = 1'b0;
  bit           rand_afull = 1'b0;
  logic [3:0]   afull_force = 4'h0;

  logic [3:0] mw, md;
  logic [7:0] mdin [4];
  assign mw = {bus.o3_fifo_wren, bus.o2_fifo_wren, bus.o1_fifo_wren, bus.o0_fifo_wren};
  assign md = {bus.o3_fifo_del, bus.o2_fifo_del, bus.o1_fifo_del, bus.o0_fifo_del};
  assign mdin[0] = bus.o0_fifo_din;
  assign mdin[1] = bus.o1_fifo_din;
  assign mdin[2] = bus.o2_fifo_din;
  assign mdin[3] = bus.o3_fifo_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Ethernet CRC-32, LSB-first bit order, one byte at a time.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic int exp_len(input int body);
    int n;
    n = 14 + body;
`ifdef MAC_ENC_PAD_EN
    if (n < MIN_FRAME) n = MIN_FRAME;
`endif
    return n + 4;
  endfunction

  function automatic logic [127:0] rand_hdr();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive();
    bus.h_fifo_empty = (hq.size() == 0);
    bus.h_fifo_dout  = (hq.size() != 0) ? hq[0] : '0;
    bus.b_fifo_empty = (bq.size() == 0) || (stall_cnt > 0);
    bus.b_fifo_dout  = (bq.size() != 0) ? bq[0][7:0] : 8'h00;
    bus.b_fifo_del   = (bq.size() != 0) ? bq[0][8] : 1'b0;
    bus.o0_fifo_afull = afull_force[0] | (rand_afull && ($urandom_range(0, 3) == 0));
    bus.o1_fifo_afull = afull_force[1] | (rand_afull && ($urandom_range(0, 3) == 0));
    bus.o2_fifo_afull = afull_force[2] | (rand_afull && ($urandom_range(0, 3) == 0));
    bus.o3_fifo_afull = afull_force[3] | (rand_afull && ($urandom_range(0, 3) == 0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (h_pop && hq.size() != 0) begin void'(hq.pop_front()); h_pop_cnt++; end
    if (b_pop && bq.size() != 0) begin void'(bq.pop_front()); b_pop_cnt++; end
    if (stall_cnt > 0) stall_cnt--;
    else if (rand_stall && $urandom_range(0, 7) == 0) stall_cnt = 1;
    drive();
  endtask

  // Reference model: the whole frame as a byte list, straight from the frame format.
  task automatic queue_frame(input logic [127:0] hbase, input logic [1:0] port,
                             input logic fcs_ok, input int len, input bit incr);
    logic [127:0] h;
    logic [7:0]   fr [$];
    logic [7:0]   d;
    logic [31:0]  c;
    h = hbase;
    h[PORT_LSB +: 2] = port;
    h[FCS_OK_BIT]    = fcs_ok;
    hq.push_back(h);
    for (int k = 0; k < 6; k++) fr.push_back(h[DST_LSB + 47 - 8*k -: 8]);
    for (int k = 0; k < 6; k++) fr.push_back(h[SRC_LSB + 47 - 8*k -: 8]);
    for (int k = 0; k < 2; k++) fr.push_back(h[TYPE_LSB + 15 - 8*k -: 8]);
    for (int i = 0; i < len; i++) begin
      d = incr ? 8'(i) : 8'($urandom);
      bq.push_back({(i == len - 1), d});
      fr.push_back(d);
    end
`ifdef MAC_ENC_PAD_EN
    while (fr.size() < MIN_FRAME) fr.push_back(8'h00);
`endif
    if (fcs_ok) begin
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < fr.size(); i++) c = crc_upd(c, fr[i]);
      c = ~c;
      for (int i = 0; i < fr.size(); i++) exp_q[port].push_back({1'b0, fr[i]});
      for (int k = 0; k < 4; k++) exp_q[port].push_back({(k == 3), c[8*k +: 8]});
    end
    drive();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!(hq.size() == 0 && bq.size() == 0 && exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
             exp_q[2].size() == 0 && exp_q[3].size() == 0) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_in_time"}, 32'(n < budget), 32'd1);
    repeat (3) step();
  endtask

  // Compare process: every cycle, every port, against the model's expected stream.
  always @(negedge clk) begin
    logic [8:0]  e;
    logic [31:0] c;
    h_pop = bus.h_fifo_rden;
    b_pop = bus.b_fifo_rden;
    if (h_pop) chk("h_pop_nonempty", 32'(bus.h_fifo_empty), 32'd0);
    if (b_pop) chk("b_pop_nonempty", 32'(bus.b_fifo_empty), 32'd0);
    for (int p = 0; p < 4; p++) begin
      if (mw[p] === 1'b1) begin
        wr_total++;
        if (exp_q[p].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: port %0d got din %02h, expected no write", p, mdin[p]);
        end else begin
          e = exp_q[p].pop_front();
          chk($sformatf("tx_p%0d_del_din", p), 32'({md[p], mdin[p]}), 32'(e));
        end
        rx_q[p].push_back(mdin[p]);
        if (rx_q[p].size() == 1) rx_first[p] = mdin[p];
        if (md[p] === 1'b1) begin
          c = 32'hFFFF_FFFF;
          for (int i = 0; i < rx_q[p].size(); i++) c = crc_upd(c, rx_q[p][i]);
          chk($sformatf("rx_p%0d_residue", p), bitrev(c), FCS_RESIDUE);
          rx_len[p] = rx_q[p].size();
          rx_q[p].delete();
          frames_done++;
        end
      end else begin
        chk($sformatf("idle_p%0d_quiet", p), 32'({mw[p], md[p], mdin[p]}), 32'd0);
      end
    end
  end

  initial begin
    logic [127:0] h;
    logic [31:0]  c;
    string        s;
    int           w0, b0, f0, h0, zeros, n;

    for (int p = 0; p < 4; p++) begin rx_len[p] = 0; rx_first[p] = 8'h00; end
    drive();
    repeat (3) step();
    chk("rst_wren", 32'(mw), 32'd0);
    chk("rst_del", 32'(md), 32'd0);
    chk("rst_din", {mdin[3], mdin[2], mdin[1], mdin[0]}, 32'd0);
    chk("rst_rden", 32'({bus.h_fifo_rden, bus.b_fifo_rden}), 32'd0);
    rst = 1'b0;
    step();

    // Pin the model's CRC against the standard check value for "123456789".
    s = "123456789";
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) c = crc_upd(c, s[i]);
    chk("model_crc_check_value", ~c, 32'hCBF4_3926);

    // 46-byte incrementing body on port 2.
    w0 = wr_total;
    h = rand_hdr();
    h[DST_LSB +: 48] = 48'h0102_0304_0506;
    queue_frame(h, 2'd2, 1'b1, 46, 1'b1);
    wait_done("frame46", 400);
    chk("frame46_len", 32'(rx_len[2]), 32'd64);
    chk("frame46_first_byte", 32'(rx_first[2]), 32'h01);
    chk("frame46_total_writes", 32'(wr_total - w0), 32'd64);

    // 10-byte body: padded to 60 when padding is built in.
    queue_frame(rand_hdr(), 2'd0, 1'b1, 10, 1'b1);
    wait_done("frame10", 400);
`ifdef MAC_ENC_PAD_EN
    chk("frame10_len", 32'(rx_len[0]), 32'd64);
`else
    chk("frame10_len", 32'(rx_len[0]), 32'd28);
`endif

    // FCS_OK=0: body drained silently, next header still serviced.
    w0 = wr_total;
    b0 = b_pop_cnt;
    queue_frame(rand_hdr(), 2'd1, 1'b0, 100, 1'b0);
    wait_done("drop100", 400);
    chk("drop100_pops", 32'(b_pop_cnt - b0), 32'd100);
    chk("drop100_writes", 32'(wr_total - w0), 32'd0);
    f0 = frames_done;
    queue_frame(rand_hdr(), 2'd1, 1'b1, 30, 1'b0);
    wait_done("after_drop", 400);
    chk("after_drop_frames", 32'(frames_done - f0), 32'd1);
    chk("after_drop_len", 32'(rx_len[1]), 32'(exp_len(30)));

    // Five-cycle body stall mid-payload.
    queue_frame(rand_hdr(), 2'd3, 1'b1, 40, 1'b1);
    n = 0;
    while (rx_q[3].size() < 20 && n < 200) begin step(); n++; end
    chk("stall_reach_payload", 32'(n < 200), 32'd1);
    stall_cnt = 5;
    drive();
    zeros = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (mw[3] == 1'b0) zeros++;
    end
    chk("stall_wren_low_cycles", 32'(zeros), 32'd5);
    wait_done("stall40", 400);
    chk("stall40_len", 32'(rx_len[3]), 32'(exp_len(40)));

    // Target FIFO almost full: header must wait, then start immediately.
    afull_force = 4'b0010;
    h0 = h_pop_cnt;
    queue_frame(rand_hdr(), 2'd1, 1'b1, 20, 1'b0);
    repeat (8) step();
    chk("afull_no_pop", 32'(h_pop_cnt - h0), 32'd0);
    chk("afull_no_write", 32'(mw), 32'd0);
    afull_force = 4'b0000;
    drive();
    step();
    chk("afull_release_pop", 32'(h_pop_cnt - h0), 32'd1);
    step();
    chk("afull_release_first_write", 32'(bus.o1_fifo_wren), 32'd1);
    wait_done("afull20", 400);
    chk("afull20_len", 32'(rx_len[1]), 32'(exp_len(20)));

    // Reset at payload byte 20, then a clean frame.
    queue_frame(rand_hdr(), 2'd3, 1'b1, 50, 1'b1);
    n = 0;
    while (rx_q[3].size() < 34 && n < 200) begin step(); n++; end
    chk("rst_reach_byte20", 32'(n < 200), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bq.delete();
    exp_q[3].delete();
    rx_q[3].delete();
    drive();
    chk("midrst_wren", 32'(mw), 32'd0);
    chk("midrst_del", 32'(md), 32'd0);
    chk("midrst_din", {mdin[3], mdin[2], mdin[1], mdin[0]}, 32'd0);
    chk("midrst_rden", 32'({bus.h_fifo_rden, bus.b_fifo_rden}), 32'd0);
    queue_frame(rand_hdr(), 2'd3, 1'b1, 46, 1'b1);
    wait_done("post_rst", 400);
    chk("post_rst_len", 32'(rx_len[3]), 32'd64);

    // Oversize frame past the counter's saturation point.
    queue_frame(rand_hdr(), 2'd0, 1'b1, 2100, 1'b0);
    wait_done("oversize", 3000);
    chk("oversize_len", 32'(rx_len[0]), 32'd2118);

    // Randomized back-to-back frames with body stalls and afull noise.
    rand_stall = 1'b1;
    rand_afull = 1'b1;
    f0 = frames_done;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      logic ok;
      ok = ($urandom_range(0, 4) != 0);
      if (ok) n++;
      queue_frame(rand_hdr(), 2'($urandom_range(0, 3)), ok, $urandom_range(1, 80), 1'b0);
    end
    wait_done("random", 8000);
    chk("random_frames", 32'(frames_done - f0), 32'(n));
    rand_stall = 1'b0;
    rand_afull = 1'b0;
    stall_cnt = 0;
    drive();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_enc.md
MAC_ENC -- requirements
Module: mac_enc

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high, on ports clk and rst.
REQ-002 clk  in  1  sole clock; all logic rises on posedge clk.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 h_fifo_dout  in  128  header word: {RSVD[11:0], FCS_OK, IS_CTRL, PORT[1:0], SRC[47:0], DST[47:0], TYPE[15:0]}; first-word-fall-through.
REQ-005 h_fifo_empty  in  1  header FIFO empty.
REQ-006 h_fifo_rden  out  1  header pop, one-cycle pulse.
REQ-007 b_fifo_dout  in  8  body byte, first-word-fall-through.
REQ-008 b_fifo_empty  in  1  body FIFO empty.
REQ-009 b_fifo_del  in  1  current b_fifo_dout is the last payload byte.
REQ-010 b_fifo_rden  out  1  body pop.
REQ-011 oN_fifo_din  out  8  TX byte to PHY N, N=0..3.
REQ-012 oN_fifo_wren  out  1  TX write strobe, PHY N.
REQ-013 oN_fifo_del  out  1  frame delimiter, asserted with the last FCS byte.
REQ-014 oN_fifo_afull  in  1  PHY N TX FIFO has less than 1,518 B free.

Function
REQ-015 States: S_IDLE, S_HDR, S_PAYLOAD, S_PAD, S_FCS, S_DROP, S_END; an undefined encoding SHALL go to S_END.
REQ-016 S_IDLE: when ~h_fifo_empty and ~oP_fifo_afull (P = h_fifo_dout PORT), latch header and port, pulse h_fifo_rden one cycle, go to S_HDR if FCS_OK=1, else go to S_DROP.
REQ-017 S_IDLE with the target afull asserted SHALL hold, with no pop and no write.
REQ-018 S_HDR SHALL emit 14 bytes on consecutive cycles: DST MSB-first, then SRC MSB-first, then TYPE MSB-first; go to S_PAYLOAD after byte 13.
REQ-019 S_PAYLOAD: when ~b_fifo_empty, pop, write the byte, and assert wren; when b_fifo_empty, wren SHALL be 0 (stall) and there SHALL be no pop.
REQ-020 A payload byte that has b_fifo_del=1 ends the payload: go to S_PAD if frame count < 60, else go to S_FCS.
REQ-021 S_PAD SHALL write 8'h00 bytes until the frame count reaches 60, then go to S_FCS.
REQ-022 S_FCS SHALL write 4 bytes of ~crc (crc over DST..last pad byte), LSB byte first, so that the receiver residue equals 32'hC704_DD7B; del is asserted on the 4th byte.
REQ-023 S_DROP SHALL pop the body until the byte with del is consumed, with no TX writes, then go to S_END.
REQ-024 S_END SHALL clear the counters, reset the CRC, deassert all strobes, and return to S_IDLE after one cycle.
REQ-025 Only the latched port's din/wren/del SHALL toggle; the other ports SHALL hold 0.
REQ-026 Frame byte counter: 11 bits, saturating at 2047; no truncation of oversize frames.
REQ-027 Output latency: TX byte registered one cycle after the pop that sourced it.
REQ-028 Mid-frame afull SHALL be ignored, because room is guaranteed at frame start.

Reset
REQ-029 rst SHALL force S_IDLE, all rden/wren/del=0, all din=8'h00, counters=0, CRC state=32'hFFFF_FFFF, and latched port=0.
REQ-030 rst mid-frame SHALL abort without emitting del; the partial frame is the PHY FIFO's concern.

Configuration
REQ-031 With macro MAC_ENC_PAD_EN defined, S_PAD SHALL be present per REQ-021.
REQ-032 Without MAC_ENC_PAD_EN, S_PAD is absent: the payload end always goes to S_FCS, and short frames are sent unpadded.

Structure
REQ-033 A shared package mac_pkg SHALL hold the header field offsets, HEADER_DWIDTH=128, MIN_FRAME=60, FCS_RESIDUE=32'hC704_DD7B, and the state encodings.
REQ-034 The existing crc sub-module (8-bit data, crc_en, rst, clk) SHALL be instantiated once; there is no other sub-module.

Verification
REQ-035 Header PORT=2, FCS_OK=1, 46-byte body 00..2D -> o2 gets 64 bytes: 14 header, 46 body, 4 FCS; del on byte 64; residue C704DD7B; o0/o1/o3 silent.
REQ-036 10-byte body with PAD_EN -> 24 data bytes then 36 x 8'h00, then FCS; total 64 B.
REQ-037 FCS_OK=0, 100-byte body -> 100 pops, zero TX writes, next header serviced.
REQ-038 b_fifo_empty asserted for 5 cycles mid-payload -> 5 cycles with wren=0, byte order intact, FCS correct.
REQ-039 o1_fifo_afull=1 with a PORT=1 header pending -> no h_fifo_rden until afull drops, then the frame starts the next cycle.
REQ-040 rst at payload byte 20 -> all outputs 0 next cycle, state S_IDLE, and the next frame is encoded correctly.
